rate_ramp_ctrl: RTL and testbench

RATE_RAMP_CTRL -- requirements
Module: rate_ramp_ctrl

---
 rtl/rate_ramp_ctrl_pkg.sv | 20 ++
 rtl/rate_ramp_ctrl_sync2.sv | 32 +++
 rtl/rate_ramp_ctrl.sv | 90 +++++++++
 tb/tb_rate_ramp_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rate_ramp_ctrl_pkg.sv
// Shared widths, defaults, FSM encoding and period decode for the rate ramp controller.
package rate_ramp_ctrl_pkg;

   localparam int unsigned RATE_W             = 3;
   localparam int unsigned CNT_W              = 25;
   localparam int unsigned DEFAULT_BASE_SHIFT = 21;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_state_e;

   // Period length (2r+1) << shift, built from concatenation and shift only.
   function automatic logic [CNT_W-1:0] period_f(input logic [RATE_W-1:0] rate,
                                                 input int unsigned       shift);
      return CNT_W'({rate, 1'b1}) << shift;
   endfunction

endpackage

// File: rtl/rate_ramp_ctrl_sync2.sv
// Parameterized-width two-flop synchronizer with a synchronous reset value.
module sync2 #(
   parameter int unsigned     W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/rate_ramp_ctrl.sv
// Animation tick generator whose period steps (or jumps) toward a requested rate,
// changing rate only at period boundaries so the tick never glitches.
module rate_ramp_ctrl
   import rate_ramp_ctrl_pkg::*;
#(
   parameter int unsigned       BASE_SHIFT = DEFAULT_BASE_SHIFT,
   parameter logic [RATE_W-1:0] RESET_RATE = 3'd0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RATE_W-1:0] target,
   input  logic              ramp_en,
   input  logic              pause,
   output logic              tick,
   output logic              period_done,
   output logic [RATE_W-1:0] rate_cur,
   output logic              busy
);

   localparam logic [RATE_W-1:0] RATE_MAX = '1;
   localparam logic [RATE_W-1:0] RATE_MIN = '0;

   logic [RATE_W-1:0] target_s;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic [CNT_W-1:0]  period_c, last_c, half_c;
   logic              at_last_c;
   ramp_state_e       state_c;

   sync2 #(
      .W       (RATE_W),
      .RST_VAL (RESET_RATE)
   ) u_target_sync (
      .clk   (clk),
      .reset (reset),
      .d     (target),
      .q     (target_s)
   );

   // Period decode, direction decision and next counter/rate.
   always_comb begin
      cnt_d     = cnt_q;
      rate_d    = rate_q;
      state_c   = IDLE;
      period_c  = period_f(rate_q, BASE_SHIFT);
      last_c    = period_c - CNT_W'(1);
      half_c    = period_c >> 1;
      at_last_c = (cnt_q == last_c);

      if (target_s > rate_q) begin
         state_c = RAMP_UP;
      end else if (target_s < rate_q) begin
         state_c = RAMP_DOWN;
      end

      if (!pause) begin
         if (at_last_c) begin
            cnt_d = '0;
            if (!ramp_en) begin
               rate_d = target_s;
            end else begin
               case (state_c)
                  RAMP_UP:   if (rate_q != RATE_MAX) rate_d = rate_q + RATE_W'(1);
                  RAMP_DOWN: if (rate_q != RATE_MIN) rate_d = rate_q - RATE_W'(1);
                  default:   rate_d = rate_q;
               endcase
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         rate_q <= RESET_RATE;
      end else begin
         cnt_q  <= cnt_d;
         rate_q <= rate_d;
      end
   end

   // Reset masks the boundary pulse; tick and busy are register decodes.
   assign tick        = (cnt_q < half_c);
   assign period_done = at_last_c && !pause && !reset;
   assign rate_cur    = rate_q;
   assign busy        = (rate_q != target_s);

endmodule

// File: tb/tb_rate_ramp_ctrl.sv
// Scoreboard bench: a cycle-level arithmetic model queues expected outputs, a monitor compares them.
module tb_rate_ramp_ctrl;

   localparam int unsigned BS = 2;
   localparam logic [2:0]  RR = 3'd0;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic [2:0] target  = 3'd0;
   logic       ramp_en = 1'b0;
   logic       pause   = 1'b0;
   logic       tick, period_done, busy;
   logic [2:0] rate_cur;

   rate_ramp_ctrl #(
      .BASE_SHIFT (BS),
      .RESET_RATE (RR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .target      (target),
      .ramp_en     (ramp_en),
      .pause       (pause),
      .tick        (tick),
      .period_done (period_done),
      .rate_cur    (rate_cur),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       tick;
      logic       pd;
      logic       busy;
      logic [2:0] rate;
      bit         chk_state;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   // Model: counter position, rate in effect, and the last two targets seen (oldest first).
   int   m_cnt  = 0;
   int   m_rate = 0;
   int   tgt_hist[$];
   bit   m_init = 1'b0;

   function automatic int per(input int r);
      return 4 * (2 * r + 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("period_done", 32'(period_done), 32'(e.pd));
         if (e.chk_state) begin
            check("tick", 32'(tick), 32'(e.tick));
            check("busy", 32'(busy), 32'(e.busy));
            check("rate_cur", 32'(rate_cur), 32'(e.rate));
         end
      end
   end

   task automatic cycle(input logic [2:0] t, input logic re, input logic pa, input logic rs);
      exp_t x;
      int   ts;
      @(posedge clk);
      #1;
      target  = t;
      ramp_en = re;
      pause   = pa;
      reset   = rs;

      x.chk_state = m_init;
      x.tick      = m_init && (m_cnt < per(m_rate) / 2);
      x.pd        = m_init && !rs && !pa && (m_cnt == per(m_rate) - 1);
      x.busy      = m_init && (m_rate != tgt_hist[0]);
      x.rate      = 3'(m_rate);
      exp_q.push_back(x);

      if (rs) begin
         m_cnt  = 0;
         m_rate = int'(RR);
         tgt_hist.delete();
         tgt_hist.push_back(int'(RR));
         tgt_hist.push_back(int'(RR));
         m_init = 1'b1;
      end else begin
         ts = tgt_hist.pop_front();
         tgt_hist.push_back(int'(t));
         if (!pa) begin
            if (m_cnt == per(m_rate) - 1) begin
               m_cnt = 0;
               if (!re)              m_rate = ts;
               else if (ts > m_rate) m_rate = m_rate + 1;
               else if (ts < m_rate) m_rate = m_rate - 1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   task automatic run_until_rate(input logic [2:0] t, input logic re, input int r, input int limit);
      int n = 0;
      while (m_rate != r && n < limit) begin
         cycle(t, re, 1'b0, 1'b0);
         n++;
      end
      check("reach_rate", 32'(m_rate), 32'(r));
   endtask

   task automatic run_until_last(input logic [2:0] t, input logic re, input int limit);
      int n = 0;
      while (m_cnt != per(m_rate) - 1 && n < limit) begin
         cycle(t, re, 1'b0, 1'b0);
         n++;
      end
      check("reach_boundary", 32'(m_cnt), 32'(per(m_rate) - 1));
   endtask

   initial begin
      logic [2:0] rt;
      logic       rre;
      tgt_hist.push_back(0);
      tgt_hist.push_back(0);

      repeat (3) cycle(3'd0, 1'b0, 1'b0, 1'b1);
      repeat (20) cycle(3'd0, 1'b0, 1'b0, 1'b0);

      // Ramp 0 -> 3, then jump 3 -> 7.
      run_until_rate(3'd3, 1'b1, 3, 200);
      repeat (30) cycle(3'd3, 1'b1, 1'b0, 1'b0);
      run_until_rate(3'd7, 1'b0, 7, 100);
      repeat (70) cycle(3'd7, 1'b0, 1'b0, 1'b0);

      // Reversal: step up to 6, then retarget to 2 mid-period.
      run_until_rate(3'd5, 1'b0, 5, 200);
      run_until_rate(3'd7, 1'b1, 6, 200);
      repeat (10) cycle(3'd7, 1'b1, 1'b0, 1'b0);
      run_until_rate(3'd2, 1'b1, 2, 400);
      repeat (20) cycle(3'd2, 1'b1, 1'b0, 1'b0);

      // Pause held across a boundary with a pending step.
      repeat (5) cycle(3'd6, 1'b1, 1'b0, 1'b0);
      run_until_last(3'd6, 1'b1, 100);
      repeat (10) cycle(3'd6, 1'b1, 1'b1, 1'b0);
      repeat (5) cycle(3'd6, 1'b1, 1'b0, 1'b0);

      // Reset mid-ramp at rate 4.
      run_until_rate(3'd0, 1'b0, 0, 200);
      run_until_rate(3'd7, 1'b1, 4, 300);
      repeat (7) cycle(3'd7, 1'b1, 1'b0, 1'b0);
      cycle(3'd7, 1'b1, 1'b0, 1'b1);
      repeat (10) cycle(3'd7, 1'b1, 1'b0, 1'b0);

      rt  = 3'd7;
      rre = 1'b1;
      repeat (2500) begin
         if ($urandom_range(39) == 0) begin
            rt  = 3'($urandom_range(7));
            rre = 1'($urandom_range(1));
         end
         cycle(rt, rre, 1'($urandom_range(15) == 0), 1'($urandom_range(499) == 0));
      end

      @(posedge clk);
      @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
